// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_control_fsm_if #(
    parameter int ALUOP_W = 2
);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_en;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               instr_done;
    logic               illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore main controller for a multi-cycle MIPS datapath with a shared ALU and memory port.
// Define MC_CTRL_BNE_EN to decode bne (opcode 000101) into its own branch state.
module mc_control_fsm #(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMRD    = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWR    = STATE_W'(5),
        S_RTYPE_EX = STATE_W'(6),
        S_RTYPE_WB = STATE_W'(7),
        S_BEQ      = STATE_W'(8),
        S_ADDI_EX  = STATE_W'(9),
        S_ADDI_WB  = STATE_W'(10),
        S_JUMP     = STATE_W'(11),
        S_BNE      = STATE_W'(12)
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    state_e state_q, state_d;
    logic   illegal_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    logic               pc_en_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c, done_c;
    logic               iord_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
    logic [1:0]         alu_src_b_c, pc_src_c;
    logic [ALUOP_W-1:0] alu_op_c;

    // Mux selects that a state does not use are left at 0.
    always_comb begin
        pc_en_c      = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        done_c       = 1'b0;
        iord_c       = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        pc_src_c     = 2'b00;
        alu_op_c     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_en_c     = bus.mem_ready;
            end
            S_DECODE: alu_src_b_c = 2'b11;
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                done_c       = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                done_c      = bus.mem_ready;
            end
            S_RTYPE_EX: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                done_c      = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = 2'b01;
                pc_en_c     = bus.zero;
                done_c      = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = 2'b01;
                pc_en_c     = ~bus.zero;
                done_c      = 1'b1;
            end
`endif
            S_JUMP: begin
                pc_src_c = 2'b10;
                pc_en_c  = 1'b1;
                done_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates every enable combinationally so an in-flight strobe drops before the next edge.
    assign bus.pc_en      = reset & pc_en_c;
    assign bus.mem_read   = reset & mem_read_c;
    assign bus.mem_write  = reset & mem_write_c;
    assign bus.ir_write   = reset & ir_write_c;
    assign bus.reg_write  = reset & reg_write_c;
    assign bus.instr_done = reset & done_c;
    assign bus.illegal_op = reset & illegal_c;

    assign bus.iord       = iord_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.pc_src     = pc_src_c;

    assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed table-driven bench for mc_control_fsm plus hand sequences for reset and latency.
module tb_mc_control_fsm;

    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // {pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op}
    localparam logic [6:0] EN_NONE = 7'b0000000;
    localparam logic [6:0] EN_FET  = 7'b1110000;
    localparam logic [6:0] EN_RD   = 7'b0010000;
    localparam logic [6:0] EN_WB   = 7'b0000110;
    localparam logic [6:0] EN_BRT  = 7'b1000010;
    localparam logic [6:0] EN_BRN  = 7'b0000010;
    localparam logic [6:0] EN_ILL  = 7'b0000001;
    localparam logic [6:0] EN_MW   = 7'b0001000;
    localparam logic [6:0] EN_MWD  = 7'b0001010;

    localparam int NV = 36;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       rdy;
        logic [3:0] st;
        logic [6:0] en;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] state;
    int         checks;
    int         passes;
    vec_t       tv[NV];

    mc_control_fsm_if #(.ALUOP_W(2)) bus ();

    mc_control_fsm #(.STATE_W(4), .ALUOP_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        else passes++;
    endtask

    function automatic logic [6:0] en_now();
        return {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.instr_done, bus.illegal_op};
    endfunction

    // {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]}
    function automatic logic [9:0] mux_now();
        return {bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src};
    endfunction

    // Selects that each state defines; everything outside the mask is don't-care.
    function automatic logic [19:0] mux_exp(input logic [3:0] st);
        case (st)
            4'd0:        return {10'b1001111111, 10'b0000010000};
            4'd1:        return {10'b0001111100, 10'b0000110000};
            4'd2, 4'd9:  return {10'b0001111100, 10'b0001100000};
            4'd3, 4'd5:  return {10'b1000000000, 10'b1000000000};
            4'd4:        return {10'b0110000000, 10'b0010000000};
            4'd6:        return {10'b0001111100, 10'b0001001000};
            4'd7:        return {10'b0110000000, 10'b0100000000};
            4'd8, 4'd12: return {10'b0001111111, 10'b0001000101};
            4'd10:       return {10'b0110000000, 10'b0000000000};
            4'd11:       return {10'b0000000011, 10'b0000000010};
            default:     return 20'd0;
        endcase
    endfunction

    task automatic run_lat(input logic [5:0] op, input int exp_cyc);
        int  cnt;
        logic done;
        cnt  = 0;
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            bus.opcode    = op;
            bus.mem_ready = 1'b1;
            bus.zero      = 1'b1;
            #2;
            if (bus.instr_done) begin
                done = 1'b1;
                cnt  = c;
            end
        end
        chk("latency", int'(op), cnt, exp_cyc);
    endtask

    initial begin
        logic [19:0] me;
        checks        = 0;
        passes        = 0;
        reset         = 1'b0;
        bus.opcode    = OP_ADDI;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        tv[0]  = '{1'b0, OP_ADDI, 1'b0, 1'b1, 4'd0,  EN_NONE};
        tv[1]  = '{1'b1, OP_ADDI, 1'b0, 1'b1, 4'd0,  EN_FET};
        tv[2]  = '{1'b1, OP_ADDI, 1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[3]  = '{1'b1, OP_ADDI, 1'b0, 1'b1, 4'd9,  EN_NONE};
        tv[4]  = '{1'b1, OP_ADDI, 1'b0, 1'b1, 4'd10, EN_WB};
        tv[5]  = '{1'b1, OP_LW,   1'b0, 1'b1, 4'd0,  EN_FET};
        tv[6]  = '{1'b1, OP_LW,   1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[7]  = '{1'b1, OP_LW,   1'b0, 1'b1, 4'd2,  EN_NONE};
        tv[8]  = '{1'b1, OP_LW,   1'b0, 1'b0, 4'd3,  EN_RD};
        tv[9]  = '{1'b1, OP_LW,   1'b0, 1'b0, 4'd3,  EN_RD};
        tv[10] = '{1'b1, OP_LW,   1'b0, 1'b1, 4'd3,  EN_RD};
        tv[11] = '{1'b1, OP_LW,   1'b0, 1'b1, 4'd4,  EN_WB};
        tv[12] = '{1'b1, OP_RT,   1'b0, 1'b0, 4'd0,  EN_RD};
        tv[13] = '{1'b1, OP_RT,   1'b0, 1'b1, 4'd0,  EN_FET};
        tv[14] = '{1'b1, OP_RT,   1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[15] = '{1'b1, OP_RT,   1'b0, 1'b1, 4'd6,  EN_NONE};
        tv[16] = '{1'b1, OP_RT,   1'b0, 1'b1, 4'd7,  EN_WB};
        tv[17] = '{1'b1, OP_BEQ,  1'b1, 1'b1, 4'd0,  EN_FET};
        tv[18] = '{1'b1, OP_BEQ,  1'b1, 1'b1, 4'd1,  EN_NONE};
        tv[19] = '{1'b1, OP_BEQ,  1'b1, 1'b1, 4'd8,  EN_BRT};
        tv[20] = '{1'b1, OP_BEQ,  1'b0, 1'b1, 4'd0,  EN_FET};
        tv[21] = '{1'b1, OP_BEQ,  1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[22] = '{1'b1, OP_BEQ,  1'b0, 1'b1, 4'd8,  EN_BRN};
        tv[23] = '{1'b1, OP_BAD,  1'b0, 1'b1, 4'd0,  EN_FET};
        tv[24] = '{1'b1, OP_BAD,  1'b0, 1'b1, 4'd1,  EN_ILL};
        tv[25] = '{1'b1, OP_J,    1'b0, 1'b1, 4'd0,  EN_FET};
        tv[26] = '{1'b1, OP_J,    1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[27] = '{1'b1, OP_J,    1'b0, 1'b1, 4'd11, EN_BRT};
        tv[28] = '{1'b1, OP_SW,   1'b0, 1'b1, 4'd0,  EN_FET};
        tv[29] = '{1'b1, OP_SW,   1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[30] = '{1'b1, OP_SW,   1'b0, 1'b1, 4'd2,  EN_NONE};
        tv[31] = '{1'b1, OP_SW,   1'b0, 1'b0, 4'd5,  EN_MW};
        tv[32] = '{1'b1, OP_SW,   1'b0, 1'b1, 4'd5,  EN_MWD};
        tv[33] = '{1'b1, OP_BNE,  1'b0, 1'b1, 4'd0,  EN_FET};
`ifdef MC_CTRL_BNE_EN
        tv[34] = '{1'b1, OP_BNE,  1'b0, 1'b1, 4'd1,  EN_NONE};
        tv[35] = '{1'b1, OP_BNE,  1'b0, 1'b1, 4'd12, EN_BRT};
`else
        tv[34] = '{1'b1, OP_BNE,  1'b0, 1'b1, 4'd1,  EN_ILL};
        tv[35] = '{1'b1, OP_BNE,  1'b0, 1'b1, 4'd0,  EN_FET};
`endif

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset         = tv[i].rst;
            bus.opcode    = tv[i].op;
            bus.zero      = tv[i].z;
            bus.mem_ready = tv[i].rdy;
            #2;
            chk("state", i, 32'(state), 32'(tv[i].st));
            chk("enables", i, 32'(en_now()), 32'(tv[i].en));
            if (tv[i].rst) begin
                me = mux_exp(tv[i].st);
                chk("mux", i, 32'(mux_now() & me[19:10]), 32'(me[9:0]));
            end
        end

        // Short mid-cycle reset pulse with FETCH held so the latency runs start in FETCH.
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset         = 1'b0;
        #2;
        reset = 1'b1;

        run_lat(OP_LW,   5);
        run_lat(OP_SW,   4);
        run_lat(OP_RT,   4);
        run_lat(OP_ADDI, 4);
        run_lat(OP_BEQ,  3);
        run_lat(OP_J,    3);

        // Reset asserted mid-MEMWR while the write strobe is waiting on memory.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.opcode    = OP_SW;
            bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #2;
        chk("memwr_state", 0, 32'(state), 32'd5);
        chk("memwr_strobe", 0, 32'(bus.mem_write), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_strobe", 0, 32'(bus.mem_write), 32'd0);
        chk("rst_state", 0, 32'(state), 32'd0);
        chk("rst_regwr", 0, 32'(bus.reg_write), 32'd0);
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        #2;
        chk("post_rst_state", 0, 32'(state), 32'd0);
        chk("post_rst_rd", 0, 32'(bus.mem_read), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Moore-style main controller that sequences a multi-cycle MIPS datapath.
- Shares one ALU and one unified instruction/data memory port across the instruction phases.
- Decodes the 6-bit opcode and walks FETCH/DECODE/execute/writeback states, asserting per-cycle enables for PC, IR, memory, register file and ALU muxes.
- Tolerates a slow memory via a ready handshake.

Parameters:
- STATE_W, 4: width of the state register and the `state` debug output.
- ALUOP_W, 2: width of `alu_op`. Encodings: 00 = add, 01 = sub, 10 = funct-decoded.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; low forces FETCH immediately
- opcode  input  6  instr[31:26] from the IR
- zero  input  1  ALU zero flag, valid in branch states
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC register load enable
- iord  output  1  0 = memory address is PC, 1 = address is ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load enable
- reg_dst  output  1  1 = rd, 0 = rt
- mem_to_reg  output  1  1 = MDR, 0 = ALUOut
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  ALUOP_W  ALU operation class
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_op  output  1  one-cycle pulse on an unknown opcode
- state  output  STATE_W  current state, for debug

Behaviour:
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPE_EX=6, RTYPE_WB=7, BEQ=8, ADDI_EX=9, ADDI_WB=10, JUMP=11, BNE=12
- Reset low: state=FETCH asynchronously. All enables and strobes forced 0 while reset is low: pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op. The remaining mux selects are don't-care.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en are asserted only when mem_ready=1; the state then advances to DECODE.
  - If mem_ready=0, hold FETCH with the same outputs, and ir_write=pc_en=0.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPE_EX
    - 000100 -> BEQ
    - 001000 -> ADDI_EX
    - 000010 -> JUMP
    - 000101 -> BNE (feature-dependent)
    - anything else -> FETCH, with illegal_op=1 for this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD if opcode=lw, else MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1; on that cycle instr_done=1 and go to FETCH. mem_write stays high through the wait.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. Next state FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Next state FETCH.
- Outputs are decoded from the state register, gated only by mem_ready, zero and reset. No output depends on opcode except in DECODE (illegal_op).
- Simultaneous events: a reset assertion in any state wins over mem_ready and zero; the in-flight write strobe drops at once and no reg_write occurs.
- Write enables are never asserted in two consecutive cycles for the same instruction, except mem_write during a memory wait.
- Unused state codes 13–15 go to FETCH on the next clock with all enables 0.
- Latencies with mem_ready=1 every cycle:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: opcode 000101 -> BNE state. Outputs are as in BEQ but pc_en=~zero, instr_done=1, next state FETCH.
- Undefined: opcode 000101 is treated as illegal (illegal_op pulse, return to FETCH) and the BNE state code is unused.

Test Plan:
- addi $t0,$zero,5 with mem_ready=1:
  - state sequence 0,1,9,10,0
  - reg_write=1 only in state 10
  - instr_done pulse at cycle 4
  - pc_en=1 only in FETCH
- lw with mem_ready low for 2 cycles in MEMRD:
  - state sequence 0,1,2,3,3,3,4,0
  - mem_read high and iord=1 for all three MEMRD cycles
  - reg_write only in MEMWB
- beq with zero=1: pc_en=1 and pc_src=01 in state 8. With zero=0: pc_en=0. Both return to FETCH next cycle.
- Opcode 111111 in DECODE: illegal_op=1 for exactly one cycle; next state FETCH; no reg_write or mem_write.
- Reset driven low mid-MEMWR while mem_write=1:
  - mem_write drops to 0 asynchronously, before the next edge
  - after release, first state is FETCH with mem_read=1
- bne with zero=0, built with and without MC_CTRL_BNE_EN:
  - defined: state 12, pc_en=1
  - undefined: illegal_op pulse, no pc_en in DECODE
